// File: rtl/key_cond_pkg.sv
// Shared types and default constants for the push-button conditioning path.
package key_cond_pkg;

    // Per-key debounce FSM states
    typedef enum logic [1:0] {
        KS_UP       = 2'd0,
        KS_CHK_DOWN = 2'd1,
        KS_DOWN     = 2'd2,
        KS_CHK_UP   = 2'd3
    } key_state_t;

    localparam int unsigned NUM_KEYS_DEFAULT        = 3;
    localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 1_000_000;  // 20 ms at 50 MHz
    localparam int unsigned COUNT_W_DEFAULT         = 4;          // one hex digit

endpackage

// File: rtl/key_debounce.sv
// One push-button channel: 2-FF synchronizer, debounce FSM, press/release pulses.
// Ports:
//   CLOCK_50      in   clock
//   KEY0          in   synchronous reset, active-low
//   key_n_in      in   raw key pin, active-low, asynchronous
//   pressed       out  debounced level, 1 = held down
//   press_pulse   out  1-cycle pulse on accepted press
//   release_pulse out  1-cycle pulse on accepted release
//   press_pulse_c out  combinational next value of press_pulse (lets the parent
//                      update counters on the same edge that registers the pulse)
module key_debounce
    import key_cond_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic CLOCK_50,
    input  logic KEY0,
    input  logic key_n_in,
    output logic pressed,
    output logic press_pulse,
    output logic release_pulse,
    output logic press_pulse_c
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync_q;
    logic             key_s;
    key_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pressed_d, release_d;

    // Synchronizer resets to the released level (pin high)
    always_ff @(posedge CLOCK_50) begin
        if (!KEY0) sync_q <= 2'b11;
        else       sync_q <= {sync_q[0], key_n_in};
    end

    assign key_s = ~sync_q[1];

    // State register
    always_ff @(posedge CLOCK_50) begin
        if (!KEY0) begin
            state_q       <= KS_UP;
            cnt_q         <= '0;
            pressed       <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            pressed       <= pressed_d;
            press_pulse   <= press_pulse_c;
            release_pulse <= release_d;
        end
    end

    // Next-state: a new level is accepted only after DEBOUNCE_CYCLES consecutive samples
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        pressed_d     = pressed;
        press_pulse_c = 1'b0;
        release_d     = 1'b0;
        case (state_q)
            KS_UP: begin
                if (key_s) begin
                    state_d = KS_CHK_DOWN;
                    cnt_d   = CNT_W'(1);
                end
            end
            KS_CHK_DOWN: begin
                if (!key_s) begin
                    state_d = KS_UP;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d       = KS_DOWN;
                    cnt_d         = '0;
                    pressed_d     = 1'b1;
                    press_pulse_c = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            KS_DOWN: begin
                if (!key_s) begin
                    state_d = KS_CHK_UP;
                    cnt_d   = CNT_W'(1);
                end
            end
            KS_CHK_UP: begin
                if (key_s) begin
                    state_d = KS_DOWN;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = KS_UP;
                    cnt_d     = '0;
                    pressed_d = 1'b0;
                    release_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = KS_UP;
                cnt_d   = '0;
            end
        endcase
    end

endmodule

// File: rtl/key_conditioner.sv
// Conditions active-low push-buttons into clean synchronous events and
// wrapping per-key press counters for the seven-segment display path.
// Ports:
//   CLOCK_50      in   clock
//   KEY0          in   synchronous reset, active-low
//   key_n_in      in   raw key pins, active-low, asynchronous
//   clr_counts    in   synchronous clear of all press counters
//   pressed       out  debounced levels, 1 = held down
//   press_pulse   out  1-cycle pulses on accepted presses
//   release_pulse out  1-cycle pulses on accepted releases
//   press_count   out  key i count at [i*COUNT_W +: COUNT_W]
//   any_press     out  OR of press_pulse
module key_conditioner
    import key_cond_pkg::*;
#(
    parameter int unsigned NUM_KEYS        = NUM_KEYS_DEFAULT,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int unsigned COUNT_W         = COUNT_W_DEFAULT
) (
    input  logic                          CLOCK_50,
    input  logic                          KEY0,
    input  logic [NUM_KEYS-1:0]           key_n_in,
    input  logic                          clr_counts,
    output logic [NUM_KEYS-1:0]           pressed,
    output logic [NUM_KEYS-1:0]           press_pulse,
    output logic [NUM_KEYS-1:0]           release_pulse,
    output logic [NUM_KEYS*COUNT_W-1:0]   press_count,
    output logic                          any_press
);

    logic [NUM_KEYS-1:0] press_next_c;

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
        logic [COUNT_W-1:0] count_q;

        key_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_deb (
            .CLOCK_50      (CLOCK_50),
            .KEY0          (KEY0),
            .key_n_in      (key_n_in[i]),
            .pressed       (pressed[i]),
            .press_pulse   (press_pulse[i]),
            .release_pulse (release_pulse[i]),
            .press_pulse_c (press_next_c[i])
        );

        // Wrapping press counter; clear wins over a same-edge increment
        always_ff @(posedge CLOCK_50) begin
            if (!KEY0)              count_q <= '0;
            else if (clr_counts)    count_q <= '0;
            else if (press_next_c[i]) count_q <= count_q + COUNT_W'(1);
        end

        assign press_count[i*COUNT_W +: COUNT_W] = count_q;
    end

    // Registered alongside press_pulse so both assert in the same cycle
    always_ff @(posedge CLOCK_50) begin
        if (!KEY0) any_press <= 1'b0;
        else       any_press <= |press_next_c;
    end

endmodule
